// File: rtl/regfile_sb_pkg.sv
// Shared types for the integer register file: default-width index/word types,
// the hardwired-zero index and ABI register names for wave tracing.
package regfile_sb_pkg;

    localparam int unsigned DefXlen  = 32;
    localparam int unsigned DefNregs = 32;
    localparam int unsigned DefIw    = $clog2(DefNregs);

    typedef logic [DefIw-1:0]   reg_index_t;
    typedef logic [DefXlen-1:0] word;

    localparam int unsigned ZeroReg = 0;

    localparam reg_index_t RegZero = reg_index_t'(0);
    localparam reg_index_t RegRa   = reg_index_t'(1);
    localparam reg_index_t RegSp   = reg_index_t'(2);
    localparam reg_index_t RegGp   = reg_index_t'(3);
    localparam reg_index_t RegTp   = reg_index_t'(4);
    localparam reg_index_t RegT0   = reg_index_t'(5);
    localparam reg_index_t RegT1   = reg_index_t'(6);
    localparam reg_index_t RegT2   = reg_index_t'(7);
    localparam reg_index_t RegS0   = reg_index_t'(8);
    localparam reg_index_t RegS1   = reg_index_t'(9);
    localparam reg_index_t RegA0   = reg_index_t'(10);
    localparam reg_index_t RegA1   = reg_index_t'(11);
    localparam reg_index_t RegA2   = reg_index_t'(12);
    localparam reg_index_t RegA3   = reg_index_t'(13);
    localparam reg_index_t RegA4   = reg_index_t'(14);
    localparam reg_index_t RegA5   = reg_index_t'(15);
    localparam reg_index_t RegA6   = reg_index_t'(16);
    localparam reg_index_t RegA7   = reg_index_t'(17);
    localparam reg_index_t RegS2   = reg_index_t'(18);
    localparam reg_index_t RegS3   = reg_index_t'(19);
    localparam reg_index_t RegS4   = reg_index_t'(20);
    localparam reg_index_t RegS5   = reg_index_t'(21);
    localparam reg_index_t RegS6   = reg_index_t'(22);
    localparam reg_index_t RegS7   = reg_index_t'(23);
    localparam reg_index_t RegS8   = reg_index_t'(24);
    localparam reg_index_t RegS9   = reg_index_t'(25);
    localparam reg_index_t RegS10  = reg_index_t'(26);
    localparam reg_index_t RegS11  = reg_index_t'(27);
    localparam reg_index_t RegT3   = reg_index_t'(28);
    localparam reg_index_t RegT4   = reg_index_t'(29);
    localparam reg_index_t RegT5   = reg_index_t'(30);
    localparam reg_index_t RegT6   = reg_index_t'(31);

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: flush clear < release clear < reserve set.
// Also exposes the combinational release mask used for same-cycle unmasking.
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NWRITE = 1,
    localparam int unsigned IW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en      [NWRITE],
    input  logic [IW-1:0]    wr_index   [NWRITE],
    input  logic             wr_release [NWRITE],
    input  logic             rsv_en,
    input  logic [IW-1:0]    rsv_index,
    input  logic             flush,
    output logic [NREGS-1:0] rel_vec,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:0] busy_q, busy_d;

    always_comb begin
        rel_vec = '0;
        for (int p = 0; p < int'(NWRITE); p++) begin
            if (wr_en[p] && wr_release[p]) begin
                rel_vec[wr_index[p]] = 1'b1;
            end
        end
        rel_vec[ZeroReg] = 1'b0;
    end

    // Later assignments override earlier ones, giving the update priority.
    always_comb begin
        busy_d = flush ? '0 : busy_q;
        busy_d = busy_d & ~rel_vec;
        if (rsv_en) begin
            busy_d[rsv_index] = 1'b1;
        end
        busy_d[ZeroReg] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with optional write-to-read bypass and a
// busy scoreboard. Index 0 reads as zero, is never busy and ignores writes.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NWRITE = 1,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned IW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IW-1:0]    rs_index   [NREAD],
    output logic [XLEN-1:0]  rs_data    [NREAD],
    output logic             rs_busy    [NREAD],
    input  logic             wr_en      [NWRITE],
    input  logic [IW-1:0]    wr_index   [NWRITE],
    input  logic [XLEN-1:0]  wr_data    [NWRITE],
    input  logic             wr_release [NWRITE],
    input  logic             rsv_en,
    input  logic [IW-1:0]    rsv_index,
    input  logic             flush,
    output logic [NREGS-1:0] busy_vec
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] rel_vec;

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NWRITE (NWRITE)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_index   (wr_index),
        .wr_release (wr_release),
        .rsv_en     (rsv_en),
        .rsv_index  (rsv_index),
        .flush      (flush),
        .rel_vec    (rel_vec),
        .busy_vec   (busy_vec)
    );

    // Ascending port loop: the highest-numbered port wins on an index clash.
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < int'(NWRITE); p++) begin
            if (wr_en[p] && (wr_index[p] != IW'(ZeroReg))) begin
                regs_d[wr_index[p]] = wr_data[p];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass is gated by rst_n so inputs driven during reset never reach the reads.
    always_comb begin
        for (int q = 0; q < int'(NREAD); q++) begin
            rs_data[q] = '0;
            rs_busy[q] = busy_vec[rs_index[q]];
            if (rs_index[q] != IW'(ZeroReg)) begin
                rs_data[q] = regs_q[rs_index[q]];
                if ((BYPASS != 0) && rst_n) begin
                    for (int p = 0; p < int'(NWRITE); p++) begin
                        if (wr_en[p] && (wr_index[p] == rs_index[q])) begin
                            rs_data[q] = wr_data[p];
                        end
                    end
                    rs_busy[q] = busy_vec[rs_index[q]] & ~rel_vec[rs_index[q]];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomised checks of regfile_sb: a bypassing and a
// non-bypassing 32x32 instance sharing stimulus, plus a 16x64 three-read instance.
module tb_regfile_sb;
    import regfile_sb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for instances A (BYPASS=1) and B (BYPASS=0)
    reg_index_t s_rs_index [2];
    logic       s_wr_en [2];
    reg_index_t s_wr_index [2];
    word        s_wr_data [2];
    logic       s_wr_release [2];
    logic       s_rsv_en;
    reg_index_t s_rsv_index;
    logic       s_flush;
    word         a_rs_data [2], b_rs_data [2];
    logic        a_rs_busy [2], b_rs_busy [2];
    logic [31:0] a_busy_vec, b_busy_vec;

    // Instance C: NREGS=16, NREAD=3, XLEN=64
    logic [3:0]  c_rs_index [3];
    logic [63:0] c_rs_data [3];
    logic        c_rs_busy [3];
    logic        c_wr_en [2];
    logic [3:0]  c_wr_index [2];
    logic [63:0] c_wr_data [2];
    logic        c_wr_release [2];
    logic        c_rsv_en;
    logic [3:0]  c_rsv_index;
    logic        c_flush;
    logic [15:0] c_busy_vec;

    logic [63:0] exp_q [$];
    logic [63:0] mdl [16];
    int n_assert = 0;
    int n_fail = 0;

    regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rs_index(s_rs_index), .rs_data(a_rs_data),
        .rs_busy(a_rs_busy), .wr_en(s_wr_en), .wr_index(s_wr_index), .wr_data(s_wr_data),
        .wr_release(s_wr_release), .rsv_en(s_rsv_en), .rsv_index(s_rsv_index),
        .flush(s_flush), .busy_vec(a_busy_vec)
    );

    regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rs_index(s_rs_index), .rs_data(b_rs_data),
        .rs_busy(b_rs_busy), .wr_en(s_wr_en), .wr_index(s_wr_index), .wr_data(s_wr_data),
        .wr_release(s_wr_release), .rsv_en(s_rsv_en), .rsv_index(s_rsv_index),
        .flush(s_flush), .busy_vec(b_busy_vec)
    );

    regfile_sb #(.XLEN(64), .NREGS(16), .NREAD(3), .NWRITE(2), .BYPASS(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .rs_index(c_rs_index), .rs_data(c_rs_data),
        .rs_busy(c_rs_busy), .wr_en(c_wr_en), .wr_index(c_wr_index), .wr_data(c_wr_data),
        .wr_release(c_wr_release), .rsv_en(c_rsv_en), .rsv_index(c_rsv_index),
        .flush(c_flush), .busy_vec(c_busy_vec)
    );

    task automatic push(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs);
        logic [63:0] exp;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s observed=%h expected=<nothing queued>", tag, obs);
            return;
        end
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < 2; p++) begin
            s_wr_en[p] = 1'b0; s_wr_index[p] = '0; s_wr_data[p] = '0; s_wr_release[p] = 1'b0;
            c_wr_en[p] = 1'b0; c_wr_index[p] = '0; c_wr_data[p] = '0; c_wr_release[p] = 1'b0;
        end
        s_rsv_en = 1'b0; s_rsv_index = '0; s_flush = 1'b0;
        c_rsv_en = 1'b0; c_rsv_index = '0; c_flush = 1'b0;
    endtask

    // Loads every register of instance C from the model through the write ports.
    task automatic preload_c();
        for (int i = 1; i < 16; i += 2) begin
            c_wr_en[0] = 1'b1; c_wr_index[0] = 4'(i); c_wr_data[0] = mdl[i];
            c_wr_en[1] = (i + 1 < 16); c_wr_index[1] = 4'(i + 1); c_wr_data[1] = mdl[(i + 1) & 15];
            tick();
        end
        clear_inputs();
    endtask

    task automatic dump_c();
        for (int i = 0; i < 16; i++) begin
            $display("dump x%0d = %h", i, u_dut_c.regs_q[i]);
        end
    endtask

    task automatic run_random(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            for (int p = 0; p < 2; p++) begin
                c_wr_en[p] = 1'($urandom_range(1));
                c_wr_index[p] = ($urandom_range(3) == 0) ? 4'd15 : 4'($urandom_range(15));
                c_wr_data[p] = {$urandom, $urandom};
            end
            for (int q = 0; q < 3; q++) begin
                logic [63:0] e;
                c_rs_index[q] = ($urandom_range(3) == 0) ? c_wr_index[q % 2] : 4'($urandom_range(15));
                e = (c_rs_index[q] == 4'd0) ? 64'd0 : mdl[c_rs_index[q]];
                for (int p = 0; p < 2; p++) begin
                    if (c_wr_en[p] && c_wr_index[p] != 4'd0 && c_wr_index[p] == c_rs_index[q]) begin
                        e = c_wr_data[p];
                    end
                end
                push(e);
            end
            #1;
            chk("c_rand_rd0", c_rs_data[0]);
            chk("c_rand_rd1", c_rs_data[1]);
            chk("c_rand_rd2", c_rs_data[2]);
            tick();
            for (int p = 0; p < 2; p++) begin
                if (c_wr_en[p] && c_wr_index[p] != 4'd0) mdl[c_wr_index[p]] = c_wr_data[p];
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        s_rs_index[0] = RegT0; s_rs_index[1] = RegZero;
        for (int q = 0; q < 3; q++) c_rs_index[q] = 4'd5;

        // In reset
        #1;
        push(64'd0); chk("reset_a_rd", a_rs_data[0]);
        push(64'd0); chk("reset_a_busy_vec", a_busy_vec);
        push(64'd0); chk("reset_b_rd", b_rs_data[0]);
        push(64'd0); chk("reset_c_rd", c_rs_data[0]);
        #21 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 32; i++) begin
            s_rs_index[0] = reg_index_t'(i); s_rs_index[1] = reg_index_t'(31 - i);
            push(64'd0); push(64'd0);
            #1;
            chk("post_reset_rd0", a_rs_data[0]);
            chk("post_reset_rd1", a_rs_data[1]);
        end
        push(64'd0); chk("post_reset_busy_vec", a_busy_vec);

        // Write x5 then reset mid-cycle
        s_rs_index[0] = RegT0;
        s_wr_en[0] = 1'b1; s_wr_index[0] = RegT0; s_wr_data[0] = 32'h1234;
        push(64'h1234); push(64'd0);
        #1;
        chk("x5_bypass_a", a_rs_data[0]);
        chk("x5_nobypass_b", b_rs_data[0]);
        tick();
        clear_inputs();
        push(64'h1234); push(64'h1234);
        #1;
        chk("x5_written_a", a_rs_data[0]);
        chk("x5_written_b", b_rs_data[0]);
        rst_n = 1'b0;
        push(64'd0); push(64'd0);
        #1;
        chk("x5_mid_reset_a", a_rs_data[0]);
        chk("x5_mid_reset_b", b_rs_data[0]);
        #1 rst_n = 1'b1;
        tick();

        // x0 immunity
        s_rs_index[0] = RegZero;
        s_wr_en[0] = 1'b1; s_wr_index[0] = RegZero; s_wr_data[0] = 32'hDEADBEEF;
        s_rsv_en = 1'b1; s_rsv_index = RegZero;
        push(64'd0);
        #1 chk("x0_bypass_a", a_rs_data[0]);
        tick();
        clear_inputs();
        push(64'd0); push(64'd0); push(64'd0); push(64'd0);
        #1;
        chk("x0_rd_a", a_rs_data[0]);
        chk("x0_busy_vec_a", a_busy_vec);
        chk("x0_rd_b", b_rs_data[0]);
        chk("x0_rs_busy_a", a_rs_busy[0]);

        // Two ports write x7 in one cycle
        s_wr_en[0] = 1'b1; s_wr_index[0] = RegT2; s_wr_data[0] = 32'h11111111;
        tick();
        clear_inputs();
        s_rs_index[0] = RegT2;
        s_wr_en[0] = 1'b1; s_wr_index[0] = RegT2; s_wr_data[0] = 32'hAAAA0000;
        s_wr_en[1] = 1'b1; s_wr_index[1] = RegT2; s_wr_data[1] = 32'h0000BBBB;
        push(64'h0000BBBB); push(64'h11111111);
        #1;
        chk("x7_same_cycle_a", a_rs_data[0]);
        chk("x7_same_cycle_b", b_rs_data[0]);
        tick();
        clear_inputs();
        push(64'h0000BBBB); push(64'h0000BBBB);
        #1;
        chk("x7_next_cycle_a", a_rs_data[0]);
        chk("x7_next_cycle_b", b_rs_data[0]);

        // Scoreboard round trip on x10
        s_rs_index[1] = RegA0;
        s_rsv_en = 1'b1; s_rsv_index = RegA0;
        push(64'd0);
        #1 chk("x10_rsv_latency_a", a_rs_busy[1]);
        tick();
        clear_inputs();
        push(64'd1); push(64'd1); push(64'h400);
        #1;
        chk("x10_busy_a", a_rs_busy[1]);
        chk("x10_busy_b", b_rs_busy[1]);
        chk("x10_busy_vec_a", a_busy_vec);
        s_wr_en[0] = 1'b1; s_wr_index[0] = RegA0; s_wr_data[0] = 32'd42; s_wr_release[0] = 1'b1;
        push(64'd0); push(64'd42); push(64'd1); push(64'd0);
        #1;
        chk("x10_release_busy_a", a_rs_busy[1]);
        chk("x10_release_data_a", a_rs_data[1]);
        chk("x10_release_busy_b", b_rs_busy[1]);
        chk("x10_release_data_b", b_rs_data[1]);
        tick();
        clear_inputs();
        push(64'd0); push(64'd42); push(64'd0);
        #1;
        chk("x10_after_busy_b", b_rs_busy[1]);
        chk("x10_after_data_b", b_rs_data[1]);
        chk("x10_after_busy_vec_a", a_busy_vec);

        // Reserve and release x3 together, then flush with a reserve of x4
        s_rsv_en = 1'b1; s_rsv_index = RegGp;
        s_wr_en[0] = 1'b1; s_wr_index[0] = RegGp; s_wr_data[0] = 32'd3; s_wr_release[0] = 1'b1;
        tick();
        clear_inputs();
        push(64'h8); push(64'h8);
        #1;
        chk("x3_rsv_rel_a", a_busy_vec);
        chk("x3_rsv_rel_b", b_busy_vec);
        s_rsv_en = 1'b1; s_rsv_index = RegS1;
        tick();
        clear_inputs();
        s_flush = 1'b1; s_rsv_en = 1'b1; s_rsv_index = RegTp;
        push(64'h208);
        #1 chk("flush_pre_edge_a", a_busy_vec);
        tick();
        clear_inputs();
        push(64'h10); push(64'h10);
        #1;
        chk("flush_rsv_a", a_busy_vec);
        chk("flush_rsv_b", b_busy_vec);

        // Instance C: preload, full read-back, then random traffic
        mdl[0] = 64'd0;
        for (int i = 1; i < 16; i++) mdl[i] = {$urandom, $urandom};
        preload_c();
        for (int i = 0; i < 16; i++) begin
            c_rs_index[i % 3] = 4'(i);
            push(mdl[i]);
            #1 chk("c_preload_rd", c_rs_data[i % 3]);
        end
        run_random(60);
        push(64'd0);
        #1 chk("c_busy_vec", c_busy_vec);
        dump_c();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with N read ports, M write ports, optional write-to-read bypass and a per-register busy scoreboard. It sits between decode/issue and writeback in the pipelined core. Decode reads operands and reserves the destination register. Writeback (one port per functional unit) writes results and releases the reservation. Register 0 is hardwired to zero and is never busy.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers (power of two, ≥ 2)
- NREAD, 2, number of read ports
- NWRITE, 1, number of write ports
- BYPASS, 1, 1 = same-cycle write data visible on read ports; 0 = visible next cycle
- IW (local), $clog2(NREGS), index width

Ports (reset is asynchronous and active-low, as decided):
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- rs_index[NREAD]  in  IW  read register index per port
- rs_data[NREAD]  out  XLEN  read data per port
- rs_busy[NREAD]  out  1  operand not yet available
- wr_en[NWRITE]  in  1  write strobe per port
- wr_index[NWRITE]  in  IW  write register index
- wr_data[NWRITE]  in  XLEN  write data
- wr_release[NWRITE]  in  1  the write also clears the busy bit of wr_index
- rsv_en  in  1  reserve (set busy) register rsv_index
- rsv_index  in  IW  register to reserve
- flush  in  1  clear all busy bits; register contents unchanged
- busy_vec  out  NREGS  full scoreboard, bit 0 always 0

## Operation
- Register array covers entries 1..NREGS-1 plus busy[1..NREGS-1]. Index 0 reads 0 and busy 0. Writes and reserves to index 0 are ignored.
- Write: if wr_en[p] and wr_index[p] != 0, then regs[wr_index[p]] <= wr_data[p] at posedge.
- Same-index writes from several ports in one cycle: the highest port number wins.
- Release: wr_release[p] is honoured only together with wr_en[p]. It clears busy[wr_index[p]].
- Reserve: rsv_en sets busy[rsv_index]. Reserving a register that is already busy leaves it busy; no count is kept.
- Priority of busy-bit updates for one register, lowest to highest: flush clear < release clear < reserve set. A reserve and a release of the same register in the same cycle leave it busy. Flush together with a reserve leaves only the reserved register busy.
- Read, BYPASS=1:
  - rs_data[q] = wr_data of the highest-numbered port p with wr_en[p] && wr_index[p]==rs_index[q] (non-zero); otherwise regs[rs_index[q]].
  - rs_busy[q] = busy[rs_index[q]] && !(a same-cycle release of that index).
- Read, BYPASS=0: rs_data[q] = regs[rs_index[q]] and rs_busy[q] = busy[rs_index[q]]. Same-cycle writes appear next cycle.
- Reads are purely combinational from inputs and state. There is no read enable.

## Timing
- Reset (rst_n low, asynchronous): all regs = 0, all busy = 0. Consequently rs_data = 0, rs_busy = 0 and busy_vec = 0 while in reset and on the first cycle after it. Release is synchronous to clk.
- Reset asserted mid-operation clears all state immediately, including pending writes and reservations. Inputs are ignored while rst_n is low.
- Write latency: 0 cycles to the read ports with BYPASS=1, 1 cycle with BYPASS=0. The array always updates at the posedge.
- Reserve latency: busy is visible on rs_busy and busy_vec the cycle after rsv_en.
- Release latency: 0 cycles with BYPASS=1 (combinational unmask), 1 cycle with BYPASS=0.
- Flush takes effect at the posedge. busy_vec reads 0 the following cycle, except for any register reserved in the same cycle.

## Structure
- The shared types package holds a `reg_index_t` typedef (IW bits) and the `word` type. The ABI register-name constants are also added there for wave tracing.
- One natural sub-module: `regfile_scoreboard`. It holds the busy bits, the flush/release/reserve priority logic and busy_vec.
- Write-port arbitration and bypass muxing are loops inside the top module.
- A simulation-only state-dump task and a preload task (all registers) are kept for the test harness.

## Test plan
- Reset: hold rst_n=0, then release. Read all indices → data 0, busy_vec = 0. Write x5 = 0x1234, then assert rst_n=0 mid-cycle → x5 reads 0 immediately.
- x0 immunity: write 0xDEADBEEF to index 0 and reserve index 0 → rs_data = 0, busy_vec[0] = 0.
- Bypass, NWRITE=2: in the same cycle, port0 writes x7 = 0xAAAA0000 and port1 writes x7 = 0x0000BBBB, with a read of x7.
  - BYPASS=1 → 0x0000BBBB in that cycle.
  - BYPASS=0 → the old value in that cycle, then 0x0000BBBB next cycle.
- Scoreboard round trip: reserve x10 → next cycle rs_busy = 1. Write x10 = 42 with release → with BYPASS=1, same cycle rs_busy = 0 and rs_data = 42.
- Simultaneous events: reserve x3 while releasing x3 → busy stays 1. In one cycle, flush while reserving x4 with x3, x9 busy → busy_vec = 1<<4.
- Parameter sweep: NREGS=16, NREAD=3, XLEN=64. Random write/read sequence checked against a reference model, including writes to index 15 (wrap-free top index).
